// File: rtl/dmem_load_ctrl.sv
// dmem_load_ctrl: streams a byte burst into data memory, holds the core in
// reset while loading, releases it, then times the run until done or timeout.
// Optional macro LOAD_CKSUM_EN adds a modulo-2^DW checksum of the burst.
module dmem_load_ctrl #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned RST_CYC = 2,
  parameter int unsigned TMO_CYC = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW:0]   cmd_len,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          cpu_reset,
  input  logic          cpu_done,
  output logic [31:0]   run_cycles,
  output logic          run_done,
  output logic          timeout
`ifdef LOAD_CKSUM_EN
  ,
  output logic [DW-1:0] cksum
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CPU_RST,
    RUN,
    DONE
  } state_t;

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   REM_ONE = 1;
  localparam logic [31:0]   RST_LAST = 32'(RST_CYC - 1);
  localparam logic [31:0]   TMO_LIM  = 32'(TMO_CYC);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   rem_q, rem_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [31:0]   rst_cnt_q, rst_cnt_d;
  logic [31:0]   run_cycles_q, run_cycles_d;
  logic          run_done_q, run_done_d;
  logic          timeout_q, timeout_d;
`ifdef LOAD_CKSUM_EN
  logic [DW-1:0] cksum_q, cksum_d;
`endif

  // Next-state and handshake decode; the first RUN cycle masks a stale done
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rem_d        = rem_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rst_cnt_d    = rst_cnt_q;
    run_cycles_d = run_cycles_q;
    run_done_d   = 1'b0;
    timeout_d    = timeout_q;
`ifdef LOAD_CKSUM_EN
    cksum_d      = cksum_q;
`endif
    cmd_ready    = 1'b0;
    s_ready      = 1'b0;
    cpu_reset    = 1'b1;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          ptr_d        = cmd_addr;
          rem_d        = cmd_len;
          timeout_d    = 1'b0;
          run_cycles_d = '0;
          rst_cnt_d    = '0;
`ifdef LOAD_CKSUM_EN
          cksum_d      = '0;
`endif
          state_d      = (cmd_len != '0) ? LOAD : CPU_RST;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = s_data;
          ptr_d       = ptr_q + PTR_ONE;
          rem_d       = rem_q - REM_ONE;
`ifdef LOAD_CKSUM_EN
          cksum_d     = cksum_q + s_data;
`endif
          if (rem_q == REM_ONE) begin
            state_d   = CPU_RST;
            rst_cnt_d = '0;
          end
        end
      end
      CPU_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d      = RUN;
          run_cycles_d = 32'd1;
        end else begin
          rst_cnt_d = rst_cnt_q + 32'd1;
        end
      end
      RUN: begin
        cpu_reset = 1'b0;
        if (cpu_done && (run_cycles_q != 32'd1)) begin
          state_d    = DONE;
          run_done_d = 1'b1;
        end else if (run_cycles_q == TMO_LIM) begin
          state_d    = DONE;
          run_done_d = 1'b1;
          timeout_d  = 1'b1;
        end else begin
          run_cycles_d = run_cycles_q + 32'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      rem_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rst_cnt_q    <= '0;
      run_cycles_q <= '0;
      run_done_q   <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef LOAD_CKSUM_EN
      cksum_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rem_q        <= rem_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rst_cnt_q    <= rst_cnt_d;
      run_cycles_q <= run_cycles_d;
      run_done_q   <= run_done_d;
      timeout_q    <= timeout_d;
`ifdef LOAD_CKSUM_EN
      cksum_q      <= cksum_d;
`endif
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign run_cycles = run_cycles_q;
  assign run_done   = run_done_q;
  assign timeout    = timeout_q;
`ifdef LOAD_CKSUM_EN
  assign cksum      = cksum_q;
`else
  // Checksum port and adder are not built in this configuration
`endif

endmodule

// File: tb/tb_dmem_load_ctrl.sv
// tb_dmem_load_ctrl: table-driven bench with a write scoreboard for
// dmem_load_ctrl, plus hand-written reset sequences.
module tb_dmem_load_ctrl;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [8:0]  cmd_len;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_reset;
  logic        cpu_done;
  logic [31:0] run_cycles;
  logic        run_done;
  logic        timeout;
`ifdef LOAD_CKSUM_EN
  logic [7:0]  cksum;
`endif

  int checks = 0;
  int errors = 0;
  logic monOn = 1'b0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t expQ[$];

  typedef struct {
    int             addr;
    int             len;
    logic [3:0][7:0] bytes;
    bit             bubble;
    int             doneAt;
    int             expRc;
    int             expTmo;
    int             expCk;
    bit             holdNext;
  } vec_t;

  vec_t vecs[7];

  dmem_load_ctrl #(
    .AW(8),
    .DW(8),
    .RST_CYC(2),
    .TMO_CYC(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .cpu_done(cpu_done),
    .run_cycles(run_cycles),
    .run_done(run_done),
    .timeout(timeout)
`ifdef LOAD_CKSUM_EN
    ,
    .cksum(cksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected write
  always @(negedge clk) begin
    if (monOn && mem_we !== 1'b0) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write actual=%0h expected=none", mem_addr);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("wr_addr", 32'(mem_addr), 32'(e.addr));
        checkOutput("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  // Runs one command end to end; entered and left at an IDLE negedge
  task automatic applyStimulus(input vec_t v, input vec_t nxt);
    int  i;
    int  k;
    bit  tog;
    bit  fin;
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = 8'(v.addr);
    cmd_len   = 9'(v.len);
    for (int j = 0; j < v.len; j++) begin
      wr_t w;
      w.addr = 8'(v.addr + j);
      w.data = v.bytes[j];
      expQ.push_back(w);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("timeout_clr", 32'(timeout), 32'd0);
    checkOutput("run_cycles_clr", run_cycles, 32'd0);
    checkOutput("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    i = 0;
    tog = 1'b0;
    while (i < v.len) begin
      checkOutput("s_ready_load", 32'(s_ready), 32'd1);
      if (v.bubble && tog) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = v.bytes[i];
        i++;
      end
      tog = ~tog;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = 8'hEE;
    checkOutput("s_ready_drop", 32'(s_ready), 32'd0);
    checkOutput("cpu_reset_hold0", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("cpu_reset_hold1", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    checkOutput("cpu_reset_rel", 32'(cpu_reset), 32'd0);
    if (v.holdNext) begin
      cmd_valid = 1'b1;
      cmd_addr  = 8'(nxt.addr);
      cmd_len   = 9'(nxt.len);
    end
    k = 0;
    fin = 1'b0;
    while (!fin && k < 300) begin
      if (cpu_reset !== 1'b0) begin
        fin = 1'b1;
      end else begin
        k++;
        checkOutput("run_cycles_cnt", run_cycles, 32'(k));
        checkOutput("cmd_ready_run", 32'(cmd_ready), 32'd0);
        cpu_done = (v.doneAt != 0) && (k >= v.doneAt);
        @(negedge clk);
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("[TB] FAIL run_bound actual=%0d expected=%0d", k, v.expRc);
    end
    checkOutput("run_len", 32'(k), 32'(v.expRc));
    checkOutput("run_cycles_end", run_cycles, 32'(v.expRc));
    checkOutput("run_done_pulse", 32'(run_done), 32'd1);
    checkOutput("timeout_end", 32'(timeout), 32'(v.expTmo));
    checkOutput("cmd_ready_done", 32'(cmd_ready), 32'd0);
`ifdef LOAD_CKSUM_EN
    checkOutput("cksum", 32'(cksum), 32'(v.expCk));
`endif
    cpu_done = 1'b0;
    @(negedge clk);
    checkOutput("run_done_single", 32'(run_done), 32'd0);
    checkOutput("run_cycles_hold", run_cycles, 32'(v.expRc));
    checkOutput("timeout_hold", 32'(timeout), 32'(v.expTmo));
    checkOutput("writes_drained", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{addr: 1,   len: 3, bytes: {8'h00, 8'd2, 8'd15, 8'd5}, bubble: 0, doneAt: 40,
                expRc: 40,  expTmo: 0, expCk: 22,    holdNext: 0};
    vecs[1] = '{addr: 254, len: 4, bytes: {8'hA3, 8'hA2, 8'hA1, 8'hA0}, bubble: 1, doneAt: 10,
                expRc: 10,  expTmo: 0, expCk: 'h86,  holdNext: 0};
    vecs[2] = '{addr: 0,   len: 0, bytes: '0, bubble: 0, doneAt: 1,
                expRc: 2,   expTmo: 0, expCk: 0,     holdNext: 0};
    vecs[3] = '{addr: 7,   len: 1, bytes: {8'h00, 8'h00, 8'h00, 8'h3C}, bubble: 0, doneAt: 0,
                expRc: 100, expTmo: 1, expCk: 'h3C,  holdNext: 0};
    vecs[4] = '{addr: 9,   len: 2, bytes: {8'h00, 8'h00, 8'd22, 8'd11}, bubble: 0, doneAt: 100,
                expRc: 100, expTmo: 0, expCk: 33,    holdNext: 0};
    vecs[5] = '{addr: 100, len: 1, bytes: {8'h00, 8'h00, 8'h00, 8'h55}, bubble: 0, doneAt: 5,
                expRc: 5,   expTmo: 0, expCk: 'h55,  holdNext: 1};
    vecs[6] = '{addr: 200, len: 0, bytes: '0, bubble: 0, doneAt: 3,
                expRc: 3,   expTmo: 0, expCk: 0,     holdNext: 0};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    cpu_done  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst_run_cycles", run_cycles, 32'd0);
    checkOutput("rst_run_done", 32'(run_done), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
`ifdef LOAD_CKSUM_EN
    checkOutput("rst_cksum", 32'(cksum), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);
    monOn = 1'b1;

    for (int n = 0; n < 7; n++) begin
      applyStimulus(vecs[n], vecs[(n + 1) % 7]);
    end

    // Reset in the middle of a 64-byte burst at address 32
    checkOutput("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = 8'd32;
    cmd_len   = 9'd64;
    for (int j = 0; j < 10; j++) begin
      wr_t w;
      w.addr = 8'(32 + j);
      w.data = 8'(8'h40 + j);
      expQ.push_back(w);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h40 + j);
      @(negedge clk);
    end
    reset   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    @(negedge clk);
    checkOutput("mid_rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    reset   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("mid_idle_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("mid_idle_s_ready", 32'(s_ready), 32'd0);
    checkOutput("mid_writes_drained", 32'(expQ.size()), 32'd0);
    @(negedge clk);
    checkOutput("mid_no_late_write", 32'(mem_we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
